// File: rtl/deser_8_pkg.sv
// Shared constants and state encoding for the 8-bit serial-to-parallel converter.
package deser_8_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // bit_count value at which the next accepted bit completes the byte
    localparam logic [CNT_W-1:0] LAST_BIT = 3'd7;

    typedef enum logic {
        StCollect = 1'b0,
        StFull    = 1'b1
    } state_e;

endpackage

// File: rtl/deser_8_if.sv
// Handshake bundle for deser_8.
//   master : producer/consumer side (drives in, in_valid, out_ready)
//   slave  : the deserializer (drives in_ready, out, out_valid, any, bit_count)
interface deser_8_if;
    import deser_8_pkg::*;

    logic              in;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic              any;
    logic [CNT_W-1:0]  bit_count;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, any, bit_count
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, any, bit_count
    );

endinterface

// File: rtl/or_8_way.sv
// 8-input OR reduction.
//   a_i : 8-bit operand
//   y_o : 1 when any bit of a_i is set
module or_8_way (
    input  logic [7:0] a_i,
    output logic       y_o
);

    assign y_o = |a_i;

endmodule

// File: rtl/deser_8.sv
// Serial-to-parallel converter: collects 8 bits LSB first, then holds the byte
// until the consumer takes it. Input is stalled while a byte is held.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : deser_8_if slave port (in/in_valid/in_ready, out/out_valid/out_ready,
//           any = OR of out, bit_count = bits gathered so far)
module deser_8
    import deser_8_pkg::*;
(
    input logic      clk,
    input logic      reset,
    deser_8_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [BYTE_W-1:0] out_q, out_d;
    logic              any_w;

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        out_d       = out_q;
        unique case (state_q)
            StCollect: begin
                if (bus.in_valid) begin
                    // Shift in from the top: after 8 shifts the first bit sits in out[0].
                    out_d = {bus.in, out_q[BYTE_W-1:1]};
                    if (bit_count_q == LAST_BIT) begin
                        bit_count_d = '0;
                        state_d     = StFull;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                end
            end
            StFull: begin
                // Consume only; no bit is accepted in the same cycle.
                if (bus.out_ready) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            bit_count_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            out_q       <= out_d;
        end
    end

    or_8_way u_or_8_way (
        .a_i (out_q),
        .y_o (any_w)
    );

    assign bus.in_ready  = (state_q == StCollect);
    assign bus.out_valid = (state_q == StFull);
    assign bus.out       = out_q;
    assign bus.bit_count = bit_count_q;
    assign bus.any       = any_w;

endmodule

// File: tb/tb_deser_8.sv
// Bench for deser_8: a directed vector table, hand-written corner sequences and
// random traffic, all checked against a bit-queue reference model.
module tb_deser_8;

    logic clk;
    logic reset;

    deser_8_if bus ();

    deser_8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits gathered so far, held byte, delivered bytes.
    bit         m_bits[$];
    bit         m_full;
    logic [7:0] m_byte;
    bit         m_out_known;
    logic [7:0] m_out;
    logic [7:0] m_delivered[$];

    // Bytes observed leaving the DUT (out_valid && out_ready at an edge).
    logic [7:0] got[$];
    bit         prev_valid;
    logic [7:0] prev_out;

    typedef struct {
        bit         rst;
        bit         din;
        bit         iv;
        bit         ordy;
        bit         exp_rdy;
        bit         exp_vld;
        logic [7:0] exp_out;
        bit         chk_out;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit b, input bit v, input bit o);
        if (r) begin
            m_bits.delete();
            m_full      = 1'b0;
            m_out_known = 1'b1;
            m_out       = 8'h00;
        end else if (m_full) begin
            if (o) begin
                m_delivered.push_back(m_byte);
                m_full      = 1'b0;
                m_out_known = 1'b0;
            end
        end else if (v) begin
            m_bits.push_back(b);
            m_out_known = 1'b0;
            if (m_bits.size() == 8) begin
                m_byte = 8'h00;
                for (int k = 0; k < 8; k++) m_byte = m_byte + (8'(m_bits[k]) << k);
                m_bits.delete();
                m_full      = 1'b1;
                m_out_known = 1'b1;
                m_out       = m_byte;
            end
        end
    endtask

    task automatic check_model();
        chk("m_in_ready", 32'(bus.in_ready), 32'(!m_full));
        chk("m_out_valid", 32'(bus.out_valid), 32'(m_full));
        chk("m_bit_count", 32'(bus.bit_count), m_bits.size());
        if (m_out_known) begin
            chk("m_out", 32'(bus.out), 32'(m_out));
            chk("m_any", 32'(bus.any), 32'(m_out != 8'h00));
        end
    endtask

    task automatic step(input bit r, input bit b, input bit v, input bit o);
        reset         = r;
        bus.in        = b;
        bus.in_valid  = v;
        bus.out_ready = o;
        if (!r && prev_valid && o) got.push_back(prev_out);
        @(posedge clk);
        model_edge(r, b, v, o);
        #1;
        check_model();
        prev_valid = bus.out_valid;
        prev_out   = bus.out;
    endtask

    task automatic send_byte(input logic [7:0] val, input bit o);
        for (int k = 0; k < 8; k++) step(1'b0, val[k], 1'b1, o);
    endtask

    task automatic add(input bit r, input bit b, input bit v, input bit o, input bit er,
                       input bit ev, input logic [7:0] eo, input bit co, input logic [2:0] ec);
        tbl.push_back('{r, b, v, o, er, ev, eo, co, ec});
    endtask

    initial begin
        logic [7:0] val;
        int         n0;
        int         nmin;

        reset         = 1'b1;
        bus.in        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        prev_valid    = 1'b0;
        prev_out      = 8'h00;
        m_full        = 1'b0;
        m_out_known   = 1'b0;
        m_out         = 8'h00;
        m_byte        = 8'h00;

        // Reset, byte 0x01, consume; then byte 0x00 held one cycle then consumed
        // with in_valid still high (that bit must not be taken).
        add(1, 0, 0, 0, 1, 0, 8'h00, 1, 3'd0);
        add(0, 1, 1, 0, 1, 0, 8'h00, 0, 3'd1);
        for (int k = 2; k < 8; k++) add(0, 0, 1, 0, 1, 0, 8'h00, 0, 3'(k));
        add(0, 0, 1, 0, 0, 1, 8'h01, 1, 3'd0);
        add(0, 0, 0, 1, 1, 0, 8'h00, 0, 3'd0);
        for (int k = 1; k < 8; k++) add(0, 0, 1, 0, 1, 0, 8'h00, 0, 3'(k));
        add(0, 0, 1, 0, 0, 1, 8'h00, 1, 3'd0);
        add(0, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].din, tbl[i].iv, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_bit_count", i), 32'(bus.bit_count), 32'(tbl[i].exp_cnt));
            if (tbl[i].chk_out) begin
                chk($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].exp_out));
                chk($sformatf("tbl%0d_any", i), 32'(bus.any), 32'(tbl[i].exp_out != 8'h00));
            end
        end

        // 0xFF held under backpressure with in_valid high.
        send_byte(8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out", 32'(bus.out), 32'hFF);
            chk("bp_bit_count", 32'(bus.bit_count), 32'd0);
        end
        n0 = got.size();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_consumed_n", got.size(), n0 + 1);
        if (got.size() == n0 + 1) chk("bp_consumed", 32'(got[n0]), 32'hFF);

        // 0x02 with in_valid toggling; invalid cycles carry in=1 as a decoy.
        val = 8'h02;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, val[k], 1'b1, 1'b0);
            chk("tog_cnt_v", 32'(bus.bit_count), 32'((k + 1) % 8));
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("tog_cnt_nv", 32'(bus.bit_count), 32'((k + 1) % 8));
        end
        chk("tog_out", 32'(bus.out), 32'h02);
        chk("tog_any", 32'(bus.any), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-byte, even with out_ready high, then a fresh byte.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_cnt_pre", 32'(bus.bit_count), 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("mid_cnt", 32'(bus.bit_count), 32'd0);
        chk("mid_out", 32'(bus.out), 32'd0);
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        send_byte(8'h5A, 1'b0);
        chk("mid_fresh", 32'(bus.out), 32'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back 0xA5, 0x3C with one stalled input cycle between.
        n0 = got.size();
        val = 8'h3C;
        send_byte(8'hA5, 1'b1);
        chk("b2b_full", 32'(bus.out_valid), 32'd1);
        step(1'b0, val[0], 1'b1, 1'b1);
        chk("b2b_stall_cnt", 32'(bus.bit_count), 32'd0);
        chk("b2b_stall_rdy", 32'(bus.in_ready), 32'd1);
        send_byte(8'h3C, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_n", got.size(), n0 + 2);
        if (got.size() == n0 + 2) begin
            chk("b2b_first", 32'(got[n0]), 32'hA5);
            chk("b2b_second", 32'(got[n0 + 1]), 32'h3C);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        chk("deliv_count", got.size(), m_delivered.size());
        nmin = (got.size() < m_delivered.size()) ? got.size() : m_delivered.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("deliv%0d", i), 32'(got[i]), 32'(m_delivered[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/deser_8.md
DESER_8 -- requirements
Module: deser_8

Interface
REQ-001 Parameter: none; width fixed at 8 bits, count width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in  input  1  serial data bit.
REQ-005 in_valid  input  1  `in` carries a bit this cycle.
REQ-006 in_ready  output  1  block accepts a bit this cycle.
REQ-007 out  output  8  assembled byte.
REQ-008 out_valid  output  1  `out` holds a complete byte.
REQ-009 out_ready  input  1  consumer takes `out` this cycle.
REQ-010 any  output  1  OR of all 8 bits of `out`, valid whenever out_valid=1.
REQ-011 bit_count  output  3  bits collected in the current byte, 0..7.

Function
REQ-012 A bit is accepted iff in_valid=1 and in_ready=1 at a rising edge.
REQ-013 Bits are assembled LSB first: the k-th accepted bit of a byte (k=0..7) lands in out[k].
REQ-014 States: COLLECT (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-015 COLLECT: each accepted bit increments bit_count; the 8th accepted bit (bit_count=7) wraps bit_count to 0 and moves to FULL on the same edge.
REQ-016 out_valid asserts the cycle after the 8th bit is accepted, a latency of 1 cycle.
REQ-017 FULL: out, any and bit_count are held stable; in_ready=0; no input bits are accepted.
REQ-018 FULL with out_ready=1: the byte is consumed; the next state is COLLECT with bit_count=0.
REQ-019 FULL with out_ready=0: the block stays in FULL indefinitely; this is lossless backpressure.
REQ-020 in_valid=0 in COLLECT: no state change, and partial bits are retained without timeout.
REQ-021 The new byte is never written over while out_valid=1; there is no overlap of consume and accept in the same cycle (1 idle input cycle per byte; throughput 8 bits per 9 cycles minimum).
REQ-022 In COLLECT, `out` shows the partial shift contents; consumers ignore it while out_valid=0.
REQ-023 `any` = OR over out[7:0], computed combinationally from the `out` register.
REQ-024 in_ready is a function of state only and does not combinationally depend on in_valid or out_ready.

Reset
REQ-025 With reset=1 at a rising edge: state COLLECT, bit_count=0, out=8'b00000000, out_valid=0, any=0, in_ready=1.
REQ-026 Reset takes priority over every other event, including mid-byte collection and FULL with out_ready=1; a partial byte is discarded.
REQ-027 Before the first reset edge, outputs are undefined; the bench applies reset for ≥1 cycle.

Structure
REQ-028 Constants BYTE_W=8, CNT_W=3 and the state encoding (COLLECT=0, FULL=1) belong in a shared package or include file.
REQ-029 The `any` function reuses the existing 8-way OR gate as its one sub-module, or_8_way, instantiated on `out`.
REQ-030 The rest of the design is flat: shift register, 3-bit counter, and 1-bit state register.

Verification
REQ-031 Reset, then serial bits 1,0,0,0,0,0,0,0 with in_valid=1 continuously -> the cycle after the 8th bit: out=8'b00000001, out_valid=1, any=1, bit_count=0.
REQ-032 Eight zero bits, then out_ready=1 -> out=8'h00, any=0, out_valid for exactly 1 cycle, in_ready=1 the next cycle.
REQ-033 Byte 8'b11111111 complete with out_ready=0 for 5 cycles while in_valid=1 -> out stable at 8'hFF and in_ready=0 throughout; no bit accepted until consumed.
REQ-034 in_valid toggled 1,0,1,0,... while sending 8'b00000010 -> assembled out=8'b00000010, any=1, and bit_count advances only on valid cycles.
REQ-035 Reset asserted after 4 accepted bits -> bit_count=0, out=0, out_valid=0; the next 8 bits form a fresh byte.
REQ-036 Back-to-back bytes 8'hA5 then 8'h3C with out_ready=1 -> both delivered in order and intact, with 1 stalled input cycle between them.
